piso_stream: RTL and testbench

- Elastic parallel-in/serial-out shift register with valid/ready handshakes on both sides.
- Per-load word count (1..NDATA) and per-load shift direction.
- Back-to-back loads with no bubble: a new load is accepted in the same cycle as the last word's output handshake.
- Sits between parallel producers (per-pixel/per-tap vectors) and serial consumers (single-word datapaths, bus packers). Generalises the plain PISO with flow control, framing and variable length.

---
 rtl/shift_pkg.sv | 22 ++
 rtl/piso_load_mux.sv | 36 +++
 rtl/piso_stream.sv | 113 +++++++++++
 tb/tb_piso_stream.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the shift-register family (PISO now, SIPO/serdes later).
// Contents:
//   DIR_LOW_FIRST / DIR_HIGH_FIRST : serialisation order of a load
//   state_e                        : ST_IDLE / ST_SHIFT control states
//   clamp_len()                    : limits a requested word count to the buffer depth
package shift_pkg;

    localparam logic DIR_LOW_FIRST  = 1'b0;
    localparam logic DIR_HIGH_FIRST = 1'b1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Requests longer than the buffer are truncated to the buffer depth.
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/piso_load_mux.sv
// Combinational builder of a buffer image from a flat parallel word vector.
// Slot i of the image receives word i (low-first) or word len-1-i (high-first);
// slots at or beyond len receive TAIL.
// Ports:
//   i_data  : flat input, word k = bits [k*BIT +: BIT]
//   i_len   : number of valid words (already clamped to 0..NDATA)
//   i_dir   : DIR_LOW_FIRST / DIR_HIGH_FIRST
//   o_image : flat output image, slot i = bits [i*BIT +: BIT]
module piso_load_mux
    import shift_pkg::*;
#(
    parameter int unsigned     BIT   = 8,
    parameter int unsigned     NDATA = 4,
    parameter logic [BIT-1:0]  TAIL  = '0,
    parameter int unsigned     CNT_W = $clog2(NDATA + 1)
) (
    input  logic [NDATA*BIT-1:0] i_data,
    input  logic [CNT_W-1:0]     i_len,
    input  logic                 i_dir,
    output logic [NDATA*BIT-1:0] o_image
);

    int unsigned w_src;

    always_comb begin
        o_image = {NDATA{TAIL}};
        w_src   = 0;
        for (int unsigned i = 0; i < NDATA; i++) begin
            if (i < 32'(i_len)) begin
                w_src = (i_dir == DIR_HIGH_FIRST) ? (32'(i_len) - 1 - i) : i;
                o_image[i*BIT +: BIT] = i_data[w_src*BIT +: BIT];
            end
        end
    end

endmodule

// File: rtl/piso_stream.sv
// Elastic parallel-in/serial-out shift register with valid/ready on both sides.
// Each load carries 1..NDATA words (longer requests clamped, zero-length loads
// accepted and dropped) and a direction. A new load is accepted in the same
// cycle as the final word's output handshake, so streams run bubble-free.
// Ports:
//   i_clk, i_rst                      : clock, synchronous active-high reset
//   i_in_valid/o_in_ready             : parallel load handshake
//   i_in_data, i_in_len, i_in_dir     : load payload, word count, order
//   o_out_valid/i_out_ready           : serial word handshake
//   o_out_data, o_out_last, o_count   : current word, final-word flag, words left
module piso_stream
    import shift_pkg::*;
#(
    parameter int unsigned    BIT   = 8,
    parameter int unsigned    NDATA = 4,
    parameter logic [BIT-1:0] TAIL  = '0,
    localparam int unsigned   CNT_W = $clog2(NDATA + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [NDATA*BIT-1:0] i_in_data,
    input  logic [CNT_W-1:0]     i_in_len,
    input  logic                 i_in_dir,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [BIT-1:0]       o_out_data,
    output logic                 o_out_last,
    output logic [CNT_W-1:0]     o_count
);

    state_e               r_state;
    state_e               w_state_d;
    logic [CNT_W-1:0]     r_count;
    logic [CNT_W-1:0]     w_count_d;
    logic [BIT-1:0]       r_buf   [NDATA];
    logic [BIT-1:0]       w_buf_d [NDATA];

    logic [CNT_W-1:0]     w_len;
    logic [NDATA*BIT-1:0] w_image;
    logic                 w_in_fire;
    logic                 w_out_fire;

    assign w_len = CNT_W'(clamp_len(32'(i_in_len), NDATA));

    piso_load_mux #(
        .BIT   (BIT),
        .NDATA (NDATA),
        .TAIL  (TAIL),
        .CNT_W (CNT_W)
    ) u_load_mux (
        .i_data  (i_in_data),
        .i_len   (w_len),
        .i_dir   (i_in_dir),
        .o_image (w_image)
    );

    // A load is only possible when empty, or when the last word leaves this cycle.
    assign o_in_ready  = !i_rst && ((r_count == '0) || ((r_count == CNT_W'(1)) && i_out_ready));
    assign o_out_valid = (r_count != '0);
    assign o_out_last  = (r_count == CNT_W'(1));
    assign o_out_data  = r_buf[0];
    assign o_count     = r_count;

    assign w_in_fire  = i_in_valid && o_in_ready;
    assign w_out_fire = o_out_valid && i_out_ready;

    always_comb begin
        w_state_d = r_state;
        w_count_d = r_count;
        w_buf_d   = r_buf;
        if (w_in_fire && (w_len != '0)) begin
            // Load wins over shift: covers the back-to-back handover.
            for (int unsigned i = 0; i < NDATA; i++) begin
                w_buf_d[i] = w_image[i*BIT +: BIT];
            end
            w_count_d = w_len;
            w_state_d = ST_SHIFT;
        end else if (w_out_fire) begin
            for (int unsigned i = 0; i < NDATA - 1; i++) begin
                w_buf_d[i] = r_buf[i+1];
            end
            w_buf_d[NDATA-1] = TAIL;
            w_count_d        = r_count - CNT_W'(1);
            w_state_d        = (r_count == CNT_W'(1)) ? ST_IDLE : ST_SHIFT;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            for (int unsigned i = 0; i < NDATA; i++) begin
                r_buf[i] <= TAIL;
            end
        end else begin
            r_state <= w_state_d;
            r_count <= w_count_d;
            r_buf   <= w_buf_d;
        end
    end

    // Invariants of the control state.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert (32'(r_count) <= NDATA);
            assert ((r_state == ST_IDLE) == (r_count == '0));
            assert (!(w_in_fire && (r_count > CNT_W'(1))));
        end
    end

endmodule

// File: tb/tb_piso_stream.sv
// Self-checking bench for piso_stream (BIT=8, NDATA=4, TAIL=0).
// Expected outputs come from a queue holding the words still owed to the consumer.
module tb_piso_stream;

    localparam int unsigned    BIT   = 8;
    localparam int unsigned    NDATA = 4;
    localparam int unsigned    CNT_W = $clog2(NDATA + 1);
    localparam logic [BIT-1:0] TAIL  = 8'h00;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [NDATA*BIT-1:0] in_data;
    logic [CNT_W-1:0]     in_len;
    logic                 in_dir;
    logic                 out_valid;
    logic                 out_ready;
    logic [BIT-1:0]       out_data;
    logic                 out_last;
    logic [CNT_W-1:0]     count;

    int n_checks;
    int n_fail;

    logic [BIT-1:0] m_q[$];

    piso_stream #(
        .BIT   (BIT),
        .NDATA (NDATA),
        .TAIL  (TAIL)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_data   (in_data),
        .i_in_len    (in_len),
        .i_in_dir    (in_dir),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_out_last  (out_last),
        .o_count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare outputs at the falling edge, then advance the model at the rising edge.
    task automatic tick();
        logic                 m_ready;
        logic                 m_in_fire;
        logic                 m_out_fire;
        logic                 s_rst;
        logic                 s_dir;
        logic [NDATA*BIT-1:0] s_data;
        int                   len_eff;
        int                   idx;
        @(negedge clk);
        m_ready = !rst && (m_q.size() == 0 || (m_q.size() == 1 && out_ready));
        chk("out_valid", out_valid, m_q.size() != 0);
        chk("out_last", out_last, m_q.size() == 1);
        chk("out_data", out_data, (m_q.size() != 0) ? m_q[0] : TAIL);
        chk("count", count, m_q.size());
        chk("in_ready", in_ready, m_ready);
        m_in_fire  = in_valid && m_ready;
        m_out_fire = (m_q.size() != 0) && out_ready;
        s_rst      = rst;
        s_dir      = in_dir;
        s_data     = in_data;
        len_eff    = (int'(in_len) > NDATA) ? NDATA : int'(in_len);
        @(posedge clk);
        if (s_rst) begin
            m_q.delete();
        end else if (m_in_fire && len_eff > 0) begin
            m_q.delete();
            for (int k = 0; k < len_eff; k++) begin
                idx = s_dir ? (len_eff - 1 - k) : k;
                m_q.push_back(s_data[idx*BIT +: BIT]);
            end
        end else if (m_out_fire) begin
            void'(m_q.pop_front());
        end
        #1;
    endtask

    task automatic set_load(input logic [31:0] words, input int len, input logic dir);
        in_valid = 1'b1;
        in_data  = words;
        in_len   = CNT_W'(len);
        in_dir   = dir;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h4433_2211;
        in_len    = 3'd4;
        in_dir    = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset held with a pending load request.
        repeat (3) tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (3) tick();

        // Low-first load followed by a held high-first load (back-to-back).
        set_load(32'h4433_2211, 4, 1'b0);
        tick();
        set_load(32'h00A2_A1A0, 3, 1'b1);
        repeat (4) tick();
        in_valid = 1'b0;
        repeat (4) tick();

        // Backpressure while 0x22 is presented.
        set_load(32'h4433_2211, 4, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        repeat (5) tick();
        out_ready = 1'b1;
        repeat (4) tick();

        // Zero length, then an over-long request.
        set_load(32'hDEAD_BEEF, 0, 1'b0);
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        set_load(32'h0403_0201, 7, 1'b0);
        tick();
        in_valid = 1'b0;
        repeat (5) tick();

        // Reset after two of four words, then a fresh load.
        set_load(32'h8877_6655, 4, 1'b0);
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        set_load(32'hCCBB_AA99, 4, 1'b1);
        tick();
        in_valid = 1'b0;
        repeat (5) tick();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 49) == 0);
            in_valid  = $urandom_range(0, 2) != 0;
            in_data   = $urandom;
            in_len    = CNT_W'($urandom_range(0, 7));
            in_dir    = 1'($urandom_range(0, 1));
            out_ready = $urandom_range(0, 3) != 0;
            tick();
        end
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
